pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline controller for the five-stage core. It collects stall requests from the IF, ID, EX and MEM stages and drives one stall vector to every pipeline register. It also takes the ID stage's branch decision and turns it into a registered PC redirect plus an IF/ID flush. It sits beside the stage chain and is the only block allowed to drive the stall and flush inputs of pipeline registers and the PC.

## Interface
Parameters:
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_from_if  input  1  IF stage requests a hold (instruction fetch wait).
- stall_from_id  input  1  ID stage `stall_request` (load-related hazard).
- stall_from_ex  input  1  EX stage requests a hold (multi-cycle op).
- stall_from_mem  input  1  MEM stage requests a hold (data memory wait).
- branch_flag  input  1  ID stage reports a taken branch this cycle.
- branch_addr  input  `ADDR_BUS  branch target from ID.
- cnt_clear  input  1  synchronous clear of both counters.
- stall  output  `STALL_BUS (6)  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  output  1  kill the IF/ID register contents (insert a bubble).
- redirect_valid  output  1  PC must load redirect_addr.
- redirect_addr  output  `ADDR_BUS  registered branch target.
- stall_cycles  output  CNT_WIDTH  count of cycles with stall[0]=1.
- flush_count  output  CNT_WIDTH  count of completed redirects.

## Operation
- stall is combinational from the requests. The highest requesting stage holds itself and every earlier stage; later stages drain.
  - mem → 6'b011111; ex → 6'b001111; id → 6'b000111; if → 6'b000011; none → 6'b000000.
  - When several requests are active, the latest stage wins.
- FSM has two states, RUN and REDIRECT.
- RUN:
  - If branch_flag=1 and stall[2]=0, capture branch_addr into redirect_addr and go to REDIRECT.
  - branch_flag while stall[2]=1 is ignored. ID still holds the instruction, so the branch is re-presented once the stall clears.
- REDIRECT:
  - redirect_valid=1 and flush=1.
  - branch_flag is ignored, because the ID content is being flushed.
  - Stay in REDIRECT while stall[0]=1, with redirect_addr frozen.
  - When stall[0]=0, go back to RUN and increment flush_count.
- flush overrides stall on the IF/ID register. That register owns the precedence; this block only guarantees that flush and stall[1] may be high together.
- Counters:
  - Both counters saturate at all-ones and never wrap.
  - cnt_clear=1 zeroes both counters. It takes priority over an increment in the same cycle.

## Timing
- Reset (rst=0, asynchronous) forces: state RUN, redirect_valid=0, flush=0, redirect_addr=0, stall_cycles=0, flush_count=0.
  - stall still follows its inputs combinationally during reset.
- Latency:
  - stall: 0 cycles from its inputs.
  - redirect_valid/flush: rise on the first edge after a qualifying branch cycle.
  - A stall-free redirect lasts exactly 1 cycle.
- A branch accepted in the same cycle as stall_from_if=1 is still captured, since stall[2]=0. The redirect then holds until stall_from_if falls.
- Reset asserted mid-REDIRECT abandons the redirect with no flush_count increment. After release the controller is in RUN.
- No back-to-back redirects: a branch can be accepted at the earliest in the cycle after REDIRECT exits.

## Structure
- Add to a shared include `ctrl.v`:
  - `STALL_BUS` (5:0).
  - Stall bit indices `STALL_PC` … `STALL_WB`.
  - The state encodings `CTRL_RUN` and `CTRL_REDIRECT`.
- One combinational sub-module, StallGen, implements the priority mapping from the four requests to the stall vector.
- The FSM, the redirect register and the counters stay in pipeline_ctrl.

## Test plan
- Priority: stall_from_if=1, stall_from_ex=1 together → stall=6'b001111. Then stall_from_mem=1 as well → 6'b011111. All released → 6'b000000.
- Clean branch: branch_flag=1 with branch_addr=32'h0000_0040 and no stalls → next cycle redirect_valid=1, flush=1, redirect_addr=32'h40. The cycle after → both 0 and flush_count=1.
- Branch blocked: branch_flag=1 while stall_from_id=1 → no redirect. Release the stall, keep branch_flag=1 → redirect one cycle later.
- Redirect held: enter REDIRECT, then stall_from_mem=1 for 3 cycles → redirect_valid and flush stay 1 for 4 cycles total, stall_cycles=3, flush_count=1 after exit.
- Reset mid-redirect: pull rst low in REDIRECT → redirect_valid, flush and both counters are 0 immediately. After release, idle with stall=0.
- Saturation and clear: with CNT_WIDTH=4, hold a stall for 20 cycles → stall_cycles=4'hF. Pulse cnt_clear during the stall → 0, then counts resume.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall bus layout,
// address width and the controller FSM state encoding.
package pipeline_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;
  localparam int NUM_REQ = 4;

  // Stall vector bit positions, earliest pipeline register first
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [STALL_W-1:0] stall_t;

  typedef enum logic {
    CTRL_RUN      = 1'b0,
    CTRL_REDIRECT = 1'b1
  } ctrl_state_e;

  // A branch may only be taken while the ID/EX boundary is moving.
  function automatic logic branch_accept(input stall_t stall_vec, input logic branch_flag);
    return branch_flag && !stall_vec[STALL_ID_EX];
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-facing bundle of the pipeline controller: stall requests and branch
// decision in, stall vector, flush and PC redirect out.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
();

  logic   stall_from_if;
  logic   stall_from_id;
  logic   stall_from_ex;
  logic   stall_from_mem;
  logic   branch_flag;
  addr_t  branch_addr;
  stall_t stall;
  logic   flush;
  logic   redirect_valid;
  addr_t  redirect_addr;

  // Pipeline stages side
  modport master (
    output stall_from_if, stall_from_id, stall_from_ex, stall_from_mem,
    output branch_flag, branch_addr,
    input  stall, flush, redirect_valid, redirect_addr
  );

  // Controller side
  modport slave (
    input  stall_from_if, stall_from_id, stall_from_ex, stall_from_mem,
    input  branch_flag, branch_addr,
    output stall, flush, redirect_valid, redirect_addr
  );

endinterface

// File: rtl/pipeline_ctrl_stall_gen.sv
// Combinational stall priority: the latest requesting stage holds itself and
// every earlier pipeline register, later registers keep draining.
module pipeline_ctrl_stall_gen
  import pipeline_ctrl_pkg::*;
(
  input  logic   stall_from_if,
  input  logic   stall_from_id,
  input  logic   stall_from_ex,
  input  logic   stall_from_mem,
  output stall_t stall
);

  logic [NUM_REQ-1:0] req;

  assign req = {stall_from_mem, stall_from_ex, stall_from_id, stall_from_if};

  // Register bit gi (gi>=1) is held when any stage at index gi-1 or later requests.
  generate
    for (genvar gi = 0; gi < STALL_W; gi++) begin : g_bit
      if (gi == STALL_PC) begin : g_pc
        assign stall[gi] = |req;
      end else if (gi == STALL_WB) begin : g_wb
        assign stall[gi] = 1'b0;
      end else begin : g_mid
        assign stall[gi] = |req[NUM_REQ-1:gi-1];
      end
    end
  endgenerate

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall vector generation, registered branch
// redirect with IF/ID flush, and saturating stall/redirect counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       bus,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  stall_t                stall_next;
  ctrl_state_e           state_reg;
  logic                  redirect_valid_reg;
  logic                  flush_reg;
  addr_t                 redirect_addr_reg;
  logic [CNT_WIDTH-1:0]  stall_cycles_reg;
  logic [CNT_WIDTH-1:0]  flush_count_reg;
  logic                  redirect_done;

  pipeline_ctrl_stall_gen u_stall_gen (
    .stall_from_if  (bus.stall_from_if),
    .stall_from_id  (bus.stall_from_id),
    .stall_from_ex  (bus.stall_from_ex),
    .stall_from_mem (bus.stall_from_mem),
    .stall          (stall_next)
  );

  assign redirect_done = (state_reg == CTRL_REDIRECT) && !stall_next[STALL_PC];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= CTRL_RUN;
      redirect_valid_reg <= 1'b0;
      flush_reg          <= 1'b0;
      redirect_addr_reg  <= '0;
    end else begin
      case (state_reg)
        CTRL_RUN: begin
          if (branch_accept(stall_next, bus.branch_flag)) begin
            state_reg          <= CTRL_REDIRECT;
            redirect_valid_reg <= 1'b1;
            flush_reg          <= 1'b1;
            redirect_addr_reg  <= bus.branch_addr;
          end
        end
        CTRL_REDIRECT: begin
          // PC is held, so the redirect must persist until it can be consumed.
          if (!stall_next[STALL_PC]) begin
            state_reg          <= CTRL_RUN;
            redirect_valid_reg <= 1'b0;
            flush_reg          <= 1'b0;
          end
        end
        default: begin
          state_reg          <= CTRL_RUN;
          redirect_valid_reg <= 1'b0;
          flush_reg          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else if (cnt_clear) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (stall_next[STALL_PC] && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
      end
      if (redirect_done && (flush_count_reg != '1)) begin
        flush_count_reg <= flush_count_reg + CNT_ONE;
      end
    end
  end

  assign bus.stall          = stall_next;
  assign bus.flush          = flush_reg;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_addr  = redirect_addr_reg;
  assign stall_cycles       = stall_cycles_reg;
  assign flush_count        = flush_count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: stall priority, branch redirect,
// blocked/held redirects, reset mid-redirect and counter saturation.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clear;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_count;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cnt_clear    (cnt_clear),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_from_if  = 1'b0;
    bus.stall_from_id  = 1'b0;
    bus.stall_from_ex  = 1'b0;
    bus.stall_from_mem = 1'b0;
    bus.branch_flag    = 1'b0;
    bus.branch_addr    = '0;
    cnt_clear          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2;
    if (bus.redirect_valid !== 1'b0) begin $display("FAIL rst_rv: got %b expected 0", bus.redirect_valid); n_fail++; end
    n_tests++;
    if (bus.flush !== 1'b0) begin $display("FAIL rst_flush: got %b expected 0", bus.flush); n_fail++; end
    n_tests++;
    if (bus.redirect_addr !== 32'h0) begin $display("FAIL rst_addr: got %h expected 0", bus.redirect_addr); n_fail++; end
    n_tests++;
    if (stall_cycles !== 4'h0 || flush_count !== 4'h0) begin
      $display("FAIL rst_cnt: got %h/%h expected 0/0", stall_cycles, flush_count); n_fail++;
    end
    n_tests++;
    bus.stall_from_if = 1'b1;
    #1;
    if (bus.stall !== 6'b000011) begin $display("FAIL rst_stall_comb: got %b expected 000011", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_if = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    if (bus.redirect_valid !== 1'b0 || stall_cycles !== 4'h0) begin
      $display("FAIL rst_release: rv=%b sc=%h expected 0/0", bus.redirect_valid, stall_cycles); n_fail++;
    end
    n_tests++;
    $display("[TB] test_reset done");
  endtask

  task automatic test_priority();
    bus.stall_from_if = 1'b1;
    bus.stall_from_ex = 1'b1;
    #1;
    if (bus.stall !== 6'b001111) begin $display("FAIL prio_if_ex: got %b expected 001111", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_mem = 1'b1;
    #1;
    if (bus.stall !== 6'b011111) begin $display("FAIL prio_mem: got %b expected 011111", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_if = 1'b0; bus.stall_from_ex = 1'b0; bus.stall_from_mem = 1'b0;
    bus.stall_from_id = 1'b1;
    #1;
    if (bus.stall !== 6'b000111) begin $display("FAIL prio_id: got %b expected 000111", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_id = 1'b0;
    bus.stall_from_if = 1'b1;
    #1;
    if (bus.stall !== 6'b000011) begin $display("FAIL prio_if: got %b expected 000011", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_if = 1'b0;
    #1;
    if (bus.stall !== 6'b000000) begin $display("FAIL prio_none: got %b expected 000000", bus.stall); n_fail++; end
    n_tests++;
    $display("[TB] test_priority done");
  endtask

  task automatic test_clean_branch();
    bus.branch_flag = 1'b1;
    bus.branch_addr = 32'h0000_0040;
    tick();
    bus.branch_flag = 1'b0;
    if (bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1) begin
      $display("FAIL clean_rise: rv=%b flush=%b expected 1/1", bus.redirect_valid, bus.flush); n_fail++;
    end
    n_tests++;
    if (bus.redirect_addr !== 32'h0000_0040) begin $display("FAIL clean_addr: got %h expected 00000040", bus.redirect_addr); n_fail++; end
    n_tests++;
    tick();
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
      $display("FAIL clean_fall: rv=%b flush=%b expected 0/0", bus.redirect_valid, bus.flush); n_fail++;
    end
    n_tests++;
    if (flush_count !== 4'h1) begin $display("FAIL clean_fc: got %h expected 1", flush_count); n_fail++; end
    n_tests++;
    $display("[TB] test_clean_branch done");
  endtask

  task automatic test_branch_blocked();
    bus.stall_from_id = 1'b1;
    bus.branch_flag   = 1'b1;
    bus.branch_addr   = 32'h0000_0080;
    tick();
    if (bus.redirect_valid !== 1'b0) begin $display("FAIL blocked_1: rv=%b expected 0", bus.redirect_valid); n_fail++; end
    n_tests++;
    tick();
    if (bus.redirect_valid !== 1'b0) begin $display("FAIL blocked_2: rv=%b expected 0", bus.redirect_valid); n_fail++; end
    n_tests++;
    if (stall_cycles !== 4'h2) begin $display("FAIL blocked_sc: got %h expected 2", stall_cycles); n_fail++; end
    n_tests++;
    bus.stall_from_id = 1'b0;
    tick();
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0000_0080) begin
      $display("FAIL blocked_release: rv=%b addr=%h expected 1/00000080", bus.redirect_valid, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    // branch_flag stays high with a new target while in REDIRECT: must be ignored
    bus.branch_addr = 32'h0000_00C0;
    tick();
    if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h0000_0080 || flush_count !== 4'h2) begin
      $display("FAIL redirect_ignore: rv=%b addr=%h fc=%h expected 0/00000080/2",
               bus.redirect_valid, bus.redirect_addr, flush_count); n_fail++;
    end
    n_tests++;
    tick();
    bus.branch_flag = 1'b0;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0000_00C0) begin
      $display("FAIL after_exit_accept: rv=%b addr=%h expected 1/000000c0", bus.redirect_valid, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    tick();
    if (flush_count !== 4'h3) begin $display("FAIL blocked_fc: got %h expected 3", flush_count); n_fail++; end
    n_tests++;
    $display("[TB] test_branch_blocked done");
  endtask

  task automatic test_if_stall_branch();
    bus.stall_from_if = 1'b1;
    bus.branch_flag   = 1'b1;
    bus.branch_addr   = 32'h0000_0044;
    tick();
    bus.branch_flag = 1'b0;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0000_0044) begin
      $display("FAIL if_branch_capture: rv=%b addr=%h expected 1/00000044", bus.redirect_valid, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    tick();
    if (bus.redirect_valid !== 1'b1) begin $display("FAIL if_branch_hold: rv=%b expected 1", bus.redirect_valid); n_fail++; end
    n_tests++;
    bus.stall_from_if = 1'b0;
    tick();
    if (bus.redirect_valid !== 1'b0 || flush_count !== 4'h4) begin
      $display("FAIL if_branch_exit: rv=%b fc=%h expected 0/4", bus.redirect_valid, flush_count); n_fail++;
    end
    n_tests++;
    $display("[TB] test_if_stall_branch done");
  endtask

  task automatic test_redirect_held();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    if (stall_cycles !== 4'h0 || flush_count !== 4'h0) begin
      $display("FAIL held_clear: sc=%h fc=%h expected 0/0", stall_cycles, flush_count); n_fail++;
    end
    n_tests++;
    bus.branch_flag = 1'b1;
    bus.branch_addr = 32'h0000_0100;
    tick();
    bus.branch_addr    = 32'h0000_0200;
    bus.stall_from_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1) begin
        $display("FAIL held_cycle%0d: rv=%b flush=%b expected 1/1", i, bus.redirect_valid, bus.flush); n_fail++;
      end
      n_tests++;
      tick();
    end
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0000_0100) begin
      $display("FAIL held_cycle3: rv=%b addr=%h expected 1/00000100", bus.redirect_valid, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    bus.stall_from_mem = 1'b0;
    bus.branch_flag    = 1'b0;
    tick();
    if (bus.redirect_valid !== 1'b0 || stall_cycles !== 4'h3 || flush_count !== 4'h1) begin
      $display("FAIL held_exit: rv=%b sc=%h fc=%h expected 0/3/1", bus.redirect_valid, stall_cycles, flush_count); n_fail++;
    end
    n_tests++;
    $display("[TB] test_redirect_held done");
  endtask

  task automatic test_saturation();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    bus.stall_from_if = 1'b1;
    repeat (20) tick();
    if (stall_cycles !== 4'hF) begin $display("FAIL sat: got %h expected f", stall_cycles); n_fail++; end
    n_tests++;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    if (stall_cycles !== 4'h0 || flush_count !== 4'h0) begin
      $display("FAIL sat_clear: sc=%h fc=%h expected 0/0", stall_cycles, flush_count); n_fail++;
    end
    n_tests++;
    tick();
    if (stall_cycles !== 4'h1) begin $display("FAIL sat_resume1: got %h expected 1", stall_cycles); n_fail++; end
    n_tests++;
    tick();
    if (stall_cycles !== 4'h2) begin $display("FAIL sat_resume2: got %h expected 2", stall_cycles); n_fail++; end
    n_tests++;
    bus.stall_from_if = 1'b0;
    $display("[TB] test_saturation done");
  endtask

  task automatic test_reset_mid_redirect();
    bus.branch_flag = 1'b1;
    bus.branch_addr = 32'h0000_0300;
    tick();
    bus.branch_flag    = 1'b0;
    bus.stall_from_mem = 1'b1;
    tick();
    if (bus.redirect_valid !== 1'b1) begin $display("FAIL mid_pre: rv=%b expected 1", bus.redirect_valid); n_fail++; end
    n_tests++;
    #1 rst = 1'b0;
    #1;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_addr !== 32'h0) begin
      $display("FAIL mid_rst_out: rv=%b flush=%b addr=%h expected 0/0/0", bus.redirect_valid, bus.flush, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    if (stall_cycles !== 4'h0 || flush_count !== 4'h0) begin
      $display("FAIL mid_rst_cnt: sc=%h fc=%h expected 0/0", stall_cycles, flush_count); n_fail++;
    end
    n_tests++;
    if (bus.stall !== 6'b011111) begin $display("FAIL mid_rst_stall: got %b expected 011111", bus.stall); n_fail++; end
    n_tests++;
    bus.stall_from_mem = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    tick();
    if (bus.redirect_valid !== 1'b0 || bus.stall !== 6'b000000 || flush_count !== 4'h0) begin
      $display("FAIL mid_idle: rv=%b stall=%b fc=%h expected 0/000000/0", bus.redirect_valid, bus.stall, flush_count); n_fail++;
    end
    n_tests++;
    bus.branch_flag = 1'b1;
    bus.branch_addr = 32'h0000_0008;
    tick();
    bus.branch_flag = 1'b0;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0000_0008) begin
      $display("FAIL mid_run_again: rv=%b addr=%h expected 1/00000008", bus.redirect_valid, bus.redirect_addr); n_fail++;
    end
    n_tests++;
    tick();
    $display("[TB] test_reset_mid_redirect done");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_clean_branch();
    test_branch_blocked();
    test_if_stall_branch();
    test_redirect_held();
    test_saturation();
    test_reset_mid_redirect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
